// File: rtl/unsigned_mul_ha_array_pipe.sv
// Two-stage approximate unsigned multiplier: rows are paired into half-adder groups, low columns approximated.
// Define UNSIGNED_MUL_HA_ARRAY_DEBUG_EN to expose the stage-1 group vectors on ha_dbg.
module unsigned_mul_ha_array_pipe #(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef UNSIGNED_MUL_HA_ARRAY_DEBUG_EN
  output logic [(WIDTH/2)*(2*WIDTH)-1:0] ha_dbg,
`endif
  output logic [2*WIDTH-1:0]   product
);

  localparam int G  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;

  logic [WIDTH:0]   t_d  [G];
  logic [WIDTH:0]   t_q  [G];
  logic [WIDTH-2:0] bv_d [G];
  logic [WIDTH-2:0] bv_q [G];

  logic          s1_valid_d, s1_valid_q;
  logic          out_valid_d, out_valid_q;
  logic [PW-1:0] product_d, product_q;
  logic [PW-1:0] sum_c;
  logic          s1_advance, s2_advance;
  logic          a, b, s, cy;

  assign s2_advance = !out_valid_q || out_ready;
  assign s1_advance = !s1_valid_q || s2_advance;
  assign in_ready   = s1_advance;
  assign out_valid  = out_valid_q;
  assign product    = product_q;

  // Column j of group g sits at absolute weight 2g+j; below APPROX_COLS it is dropped, at it the
  // pair is OR-ed, above it a true half adder is used.
  always_comb begin
    a  = 1'b0;
    b  = 1'b0;
    s  = 1'b0;
    cy = 1'b0;
    for (int g = 0; g < G; g++) begin
      t_d[g]    = '0;
      bv_d[g]   = '0;
      t_d[g][0] = x[2*g] & y[0];
      for (int j = 1; j < WIDTH; j++) begin
        a = x[2*g] & y[j];
        b = x[2*g+1] & y[j-1];
        if ((2*g + j) < APPROX_COLS) begin
          s  = 1'b0;
          cy = 1'b0;
        end else if ((2*g + j) == APPROX_COLS) begin
          s  = a | b;
          cy = 1'b0;
        end else begin
          s  = a ^ b;
          cy = a & b;
        end
        t_d[g][j] = s;
        if (j == WIDTH - 1) begin
          t_d[g][WIDTH] = cy;
        end else begin
          bv_d[g][j-1] = cy;
        end
      end
      bv_d[g][WIDTH-2] = x[2*g+1] & y[WIDTH-1];
    end
  end

  always_comb begin
    sum_c = '0;
    for (int g = 0; g < G; g++) begin
      sum_c = sum_c + ((PW'(t_q[g]) + (PW'(bv_q[g]) << 2)) << (2*g));
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    product_d   = product_q;
    if (s1_advance) begin
      s1_valid_d = in_valid;
    end
    if (s2_advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        product_d = sum_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      product_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      product_q   <= product_d;
    end
  end

  // Operand vectors are qualified by s1_valid_q, so they load without reset.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      t_q  <= t_d;
      bv_q <= bv_d;
    end
  end

`ifdef UNSIGNED_MUL_HA_ARRAY_DEBUG_EN
  for (genvar g = 0; g < G; g++) begin : g_dbg
    assign ha_dbg[g*PW +: PW] = {bv_q[g], t_q[g]};
  end
`endif

endmodule

// File: tb/tb_unsigned_mul_ha_array_pipe.sv
// Bench for unsigned_mul_ha_array_pipe: three instances (APPROX_COLS 0, 4, 15) share one stimulus
// stream and are checked every cycle against an arithmetic reference model plus literal vectors.
module tb_unsigned_mul_ha_array_pipe;

  localparam int W  = 8;
  localparam int PW = 2 * W;
  localparam int G  = W / 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          inValid = 1'b0;
  logic          outReady = 1'b1;
  logic [W-1:0]  xIn = '0;
  logic [W-1:0]  yIn = '0;
  logic          rdy0, rdy4, rdy15, vld0, vld4, vld15;
  logic [PW-1:0] prod0, prod4, prod15;
`ifdef UNSIGNED_MUL_HA_ARRAY_DEBUG_EN
  logic [G*PW-1:0] dbg0, dbg4, dbg15;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           age;
  } item_t;

  item_t         sb[$];
  logic          expValid, expReady, prevHold;
  logic [PW-1:0] prevProd, holdProd;

  always #5 clk = ~clk;

  unsigned_mul_ha_array_pipe #(.WIDTH(W), .APPROX_COLS(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(rdy0), .x(xIn), .y(yIn),
    .out_valid(vld0), .out_ready(outReady),
`ifdef UNSIGNED_MUL_HA_ARRAY_DEBUG_EN
    .ha_dbg(dbg0),
`endif
    .product(prod0));

  unsigned_mul_ha_array_pipe #(.WIDTH(W), .APPROX_COLS(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(rdy4), .x(xIn), .y(yIn),
    .out_valid(vld4), .out_ready(outReady),
`ifdef UNSIGNED_MUL_HA_ARRAY_DEBUG_EN
    .ha_dbg(dbg4),
`endif
    .product(prod4));

  unsigned_mul_ha_array_pipe #(.WIDTH(W), .APPROX_COLS(15)) dut15 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(rdy15), .x(xIn), .y(yIn),
    .out_valid(vld15), .out_ready(outReady),
`ifdef UNSIGNED_MUL_HA_ARRAY_DEBUG_EN
    .ha_dbg(dbg15),
`endif
    .product(prod15));

  // Each column pair contributes its arithmetic value (p+q) when exact, p|q at the boundary, nothing below.
  function automatic logic [PW-1:0] approxMul(input logic [W-1:0] a, input logic [W-1:0] b, input int ac);
    int unsigned total;
    int unsigned p, q;
    total = 0;
    for (int g = 0; g < G; g++) begin
      total += ((a >> (2*g)) & 1) * (b & 1) << (2*g);
      total += (((a >> (2*g+1)) & 1) * ((b >> (W-1)) & 1)) << (2*g + W);
      for (int j = 1; j < W; j++) begin
        p = (a >> (2*g)) & (b >> j) & 1;
        q = (a >> (2*g+1)) & (b >> (j-1)) & 1;
        if ((2*g + j) == ac) total += (p | q) << (2*g + j);
        else if ((2*g + j) > ac) total += (p + q) << (2*g + j);
      end
    end
    return PW'(total);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    inValid = 1'b1;
    xIn     = a;
    yIn     = b;
    forever begin
      @(negedge clk);
      if (rdy0) break;
      n++;
      if (n > 20) begin
        tests++;
        fails++;
        $display("[TB] FAIL accept_timeout: got no in_ready expected acceptance within 20 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  task automatic runOne(input logic [W-1:0] a, input logic [W-1:0] b, input int e0, input int e4, input int e15);
    applyStimulus(a, b);
    @(negedge clk);
    checkOutput("lat1_valid", 32'(vld0), 0);
    @(negedge clk);
    checkOutput("lat2_valid", 32'(vld0), 1);
    if (e0 >= 0) checkOutput("lit_prod0", 32'(prod0), e0);
    if (e4 >= 0) checkOutput("lit_prod4", 32'(prod4), e4);
    if (e15 >= 0) checkOutput("lit_prod15", 32'(prod15), e15);
  endtask

  // Scoreboard: an item is in the output stage once it has aged two edges and is at the head.
  initial begin
    prevHold = 1'b0;
    prevProd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        prevHold = 1'b0;
      end else begin
        expValid = (sb.size() > 0) && (sb[0].age >= 2);
        expReady = !((sb.size() >= 2) && !outReady);
        checkOutput("in_ready0", 32'(rdy0), 32'(expReady));
        checkOutput("in_ready4", 32'(rdy4), 32'(expReady));
        checkOutput("in_ready15", 32'(rdy15), 32'(expReady));
        checkOutput("out_valid0", 32'(vld0), 32'(expValid));
        checkOutput("out_valid4", 32'(vld4), 32'(expValid));
        checkOutput("out_valid15", 32'(vld15), 32'(expValid));
        if (expValid) begin
          checkOutput("model_prod0", 32'(prod0), 32'(approxMul(sb[0].a, sb[0].b, 0)));
          checkOutput("model_prod4", 32'(prod4), 32'(approxMul(sb[0].a, sb[0].b, 4)));
          checkOutput("model_prod15", 32'(prod15), 32'(approxMul(sb[0].a, sb[0].b, 15)));
        end
        if (prevHold) checkOutput("hold_prod0", 32'(prod0), 32'(prevProd));
        prevHold = expValid && !outReady;
        prevProd = prod0;
        if (expValid && outReady) void'(sb.pop_front());
        foreach (sb[i]) sb[i].age++;
        if (inValid && expReady) sb.push_back('{a: xIn, b: yIn, age: 1});
      end
    end
  end

  initial begin
    int n;
    checkOutput("pin_model_a0_255", 32'(approxMul(8'd255, 8'd255, 0)), 65025);
    checkOutput("pin_model_a4_3", 32'(approxMul(8'd3, 8'd3, 4)), 1);
    checkOutput("pin_model_a4_1", 32'(approxMul(8'd1, 8'd1, 4)), 1);
    checkOutput("pin_model_a15_255", 32'(approxMul(8'd255, 8'd255, 15)), 21845);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(vld0), 0);
    checkOutput("rst_product", 32'(prod0), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", 32'(rdy0), 1);

    runOne(8'd255, 8'd255, 65025, -1, 21845);
    runOne(8'd3, 8'd3, 9, 1, 1);
    runOne(8'd1, 8'd1, 1, 1, 1);

    @(posedge clk);
    #1;
    outReady = 1'b0;
    applyStimulus(8'd10, 8'd20);
    applyStimulus(8'd7, 8'd9);
    @(negedge clk);
    checkOutput("bp_ready", 32'(rdy0), 0);
    holdProd = prod0;
    repeat (5) @(negedge clk);
    checkOutput("bp_stable", 32'(prod0), 32'(holdProd));
    checkOutput("bp_valid", 32'(vld0), 1);
    checkOutput("bp_front", 32'(prod0), 200);
    @(posedge clk);
    #1;
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("drain_first", 32'(prod0), 200);
    @(negedge clk);
    checkOutput("drain_second", 32'(prod0), 63);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      inValid  = 1'($urandom_range(0, 1));
      xIn      = W'($urandom);
      yIn      = W'($urandom);
      outReady = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    inValid  = 1'b0;
    outReady = 1'b1;
    repeat (5) @(posedge clk);

    #1;
    outReady = 1'b0;
    applyStimulus(8'd12, 8'd13);
    applyStimulus(8'd14, 8'd15);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("midrst_valid", 32'(vld0), 0);
    checkOutput("midrst_ready", 32'(rdy0), 1);
    repeat (10) begin
      @(negedge clk);
      checkOutput("no_stale", 32'(vld0), 0);
    end

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scoreboard_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
